// File: rtl/reg_bank_reader.sv
// Streams register bank contents out over valid/ready, either one register or a burst
// from a start address up to the last register. Read-only toward the bank.
module reg_bank_reader #(
  parameter int unsigned D = 7,
  parameter int unsigned A = 3,
  parameter int unsigned N = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*D-1:0] regs_in,
  input  logic           rd_start,
  input  logic           rd_burst,
  input  logic [A-1:0]   rd_addr,
  input  logic           rd_abort,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [D-1:0]   out_data,
  output logic [A-1:0]   out_addr,
  output logic           out_last,
  output logic           busy,
  output logic           rd_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam logic [A-1:0] LastAddr = A'(N - 1);

  logic [0:0]   state_q, state_d;
  logic         valid_q, valid_d;
  logic [D-1:0] data_q, data_d;
  logic [A-1:0] addr_q, addr_d;
  logic         last_q, last_d;
  logic [A-1:0] end_addr_q, end_addr_d;
  logic         rd_err_q, rd_err_d;

  logic [A-1:0] next_addr;
  logic [A-1:0] sel_addr;
  logic [D-1:0] sel_data;
  logic         start_ok;
  logic         start_bad;

  // next_addr only matters when the current beat is not the last, so it never overflows
  assign next_addr = addr_q + 1'b1;
  assign start_ok  = rd_start && (32'(rd_addr) < N);
  assign start_bad = rd_start && (32'(rd_addr) >= N);
  assign sel_addr  = (state_q == StIdle) ? rd_addr : next_addr;

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(sel_addr) == k) sel_data = regs_in[k*D +: D];
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    addr_d     = addr_q;
    last_d     = last_q;
    end_addr_d = end_addr_q;
    rd_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d    = StSend;
          valid_d    = 1'b1;
          data_d     = sel_data;
          addr_d     = rd_addr;
          end_addr_d = rd_burst ? LastAddr : rd_addr;
          last_d     = !rd_burst || (rd_addr == LastAddr);
        end else if (start_bad) begin
          rd_err_d = 1'b1;
        end
      end
      StSend: begin
        // Abort wins over advancing; a coinciding handshake still counts as delivered.
        if (rd_abort || (out_ready && last_q)) begin
          state_d = StIdle;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (out_ready) begin
          addr_d = next_addr;
          data_d = sel_data;
          last_d = (next_addr == end_addr_q);
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      end_addr_q <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      end_addr_q <= end_addr_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = (state_q == StSend);
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the expected beat sequence.
module tb_reg_bank_reader;

  localparam int unsigned D = 7;
  localparam int unsigned A = 3;
  localparam int unsigned N = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*D-1:0] regs_in;
  logic           rd_start = 1'b0;
  logic           rd_burst = 1'b0;
  logic [A-1:0]   rd_addr = '0;
  logic           rd_abort = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [D-1:0]   out_data;
  logic [A-1:0]   out_addr;
  logic           out_last;
  logic           busy;
  logic           rd_err;

  logic [D-1:0] regs [N];

  int total = 0;
  int bad = 0;

  // Model: addresses still owed to the consumer, plus the snapshot of the visible beat.
  int           m_q[$];
  bit           m_active = 1'b0;
  logic [D-1:0] m_data = '0;
  bit           m_err = 1'b0;

  reg_bank_reader #(.D(D), .A(A), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .regs_in  (regs_in),
    .rd_start (rd_start),
    .rd_burst (rd_burst),
    .rd_addr  (rd_addr),
    .rd_abort (rd_abort),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .busy     (busy),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    regs_in = '0;
    for (int k = 0; k < N; k++) regs_in[k*D +: D] = regs[k];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_err    = 1'b0;
  endtask

  // Called just after a rising edge; inputs are still the values the DUT sampled.
  task automatic model_edge();
    int last;
    m_err = 1'b0;
    if (!m_active) begin
      if (rd_start) begin
        if (int'(rd_addr) >= N) begin
          m_err = 1'b1;
        end else begin
          last = rd_burst ? N - 1 : int'(rd_addr);
          m_q.delete();
          for (int a = int'(rd_addr); a <= last; a++) m_q.push_back(a);
          m_active = 1'b1;
          m_data   = regs[m_q[0]];
        end
      end
    end else if (rd_abort) begin
      m_q.delete();
      m_active = 1'b0;
    end else if (out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_active = 1'b0;
      else m_data = regs[m_q[0]];
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(out_valid), 32'(m_active));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("rd_err", 32'(rd_err), 32'(m_err));
    check_eq("last", 32'(out_last), 32'(m_active && m_q.size() == 1));
    if (m_active) begin
      check_eq("addr", 32'(out_addr), 32'(m_q[0]));
      check_eq("data", 32'(out_data), 32'(m_data));
    end
  endtask

  task automatic check_reset();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_addr", 32'(out_addr), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(rd_err), 32'd0);
  endtask

  // Entered and left just after a falling edge.
  task automatic step(input bit s, input bit b, input int unsigned ad, input bit ab,
                      input bit rdy);
    rd_start  = s;
    rd_burst  = b;
    rd_addr   = A'(ad);
    rd_abort  = ab;
    out_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int k = 0; k < N; k++) regs[k] = D'(k * 9 + 3);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    model_reset();

    // Single read
    regs[3] = 7'h55;
    step(1, 0, 3, 0, 1);
    step(0, 0, 0, 0, 1);

    // Full burst 0..6
    for (int k = 0; k < N; k++) regs[k] = D'(k + 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0, 1);

    // Backpressure with snapshot hold
    step(1, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0);
    regs[4] = 7'h2a;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Out-of-range start
    step(1, 0, 7, 0, 1);
    step(0, 0, 0, 0, 1);

    // Abort coinciding with the address-2 handshake
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Start and abort together in IDLE: start wins
    step(1, 0, 2, 1, 0);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset during the address-3 beat
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, N - 1)] = D'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Read-side companion to the decoded-select register bank write path.
- Takes the live contents of the seven D-bit bank registers and returns them to a consumer over a valid/ready stream.
- Supports a single-register read or a burst from a start address up to the last register.
- Sits between the register bank outputs and any readback/debug consumer; it never writes the bank.

Parameters:
- D, 7, data width of each bank register.
- A, 3, address width; address k selects register k+1 (address 0 = register 1).
- N, 7, number of registers in the bank; valid addresses 0..N-1, N <= 2^A.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- regs_in  input  N*D  bank contents; bits [k*D +: D] = register at address k.
- rd_start  input  1  read request; sampled only in IDLE.
- rd_burst  input  1  sampled with rd_start; 0 = single read, 1 = burst to address N-1.
- rd_addr  input  A  start address, sampled with rd_start.
- rd_abort  input  1  terminates an active read.
- out_ready  input  1  consumer accepts the current beat.
- out_valid  output  1  beat available.
- out_data  output  D  register value for the current beat.
- out_addr  output  A  address of the current beat.
- out_last  output  1  current beat is the final beat of the read.
- busy  output  1  read in progress (SEND state).
- rd_err  output  1  one-cycle pulse: rd_start with rd_addr >= N.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; out_valid, out_data, out_addr, out_last, busy and rd_err all 0. A read in progress is dropped with no further beats.
- State machine: two states, IDLE and SEND.
- IDLE, rd_start=1, rd_addr < N:
  - Next edge: out_data <= regs_in[rd_addr]; out_addr <= rd_addr; end_addr <= (rd_burst ? N-1 : rd_addr).
  - out_last <= (rd_addr == end_addr); out_valid <= 1; busy <= 1; go to SEND.
  - Latency: first beat valid 1 cycle after the rd_start edge.
- IDLE, rd_start=1, rd_addr >= N: rd_err=1 for exactly one cycle; stay IDLE; no beat produced.
- rd_err is 0 in every other cycle.
- SEND, out_valid=1, out_ready=0: out_data, out_addr and out_last hold stable. Data is a snapshot; later regs_in changes do not alter the held beat.
- SEND, handshake (out_valid & out_ready), out_last=0: next edge out_addr <= out_addr+1; out_data <= regs_in[out_addr+1] sampled at that edge; out_last updated; out_valid stays 1. Back-to-back beats are possible, one per cycle.
- SEND, handshake with out_last=1: next edge out_valid, out_last and busy go to 0; go to IDLE. A new rd_start is accepted from the following cycle.
- Address range: a burst runs start..N-1 with no wrap-around and delivers N-start beats.
- rd_abort in SEND: next edge out_valid, out_last and busy go to 0; go to IDLE.
  - If abort coincides with a handshake, that beat counts as delivered and no further beats follow. Abort has priority over advancing.
  - rd_abort in IDLE is ignored.
- rd_start while busy=1 is ignored; no queuing.
- rd_start and rd_abort in the same IDLE cycle: start is accepted.
- out_data and out_addr keep their last values after returning to IDLE; only out_valid qualifies them.

Test Plan:
- Single read: regs_in addr3 = 7'h55; rd_start, rd_burst=0, rd_addr=3, out_ready=1 -> next cycle out_valid=1, out_data=7'h55, out_addr=3, out_last=1; following cycle busy=0.
- Full burst: registers = 7'h01..7'h07; rd_addr=0, rd_burst=1, out_ready=1 -> 7 consecutive beats, data 01..07, addresses 0..6, out_last only on address 6.
- Backpressure: burst from rd_addr=4 with out_ready=0 for 3 cycles on the first beat, and regs_in addr4 changed mid-stall -> beat holds the original value; then 3 beats total (addresses 4, 5, 6).
- Error: rd_start, rd_addr=7 -> rd_err=1 for one cycle, out_valid stays 0, busy stays 0.
- Abort: burst from 0, assert rd_abort together with the handshake on the address-2 beat -> beats 0, 1, 2 delivered, out_valid=0 next cycle, IDLE.
- Reset mid-burst: drive rst=0 asynchronously during the address-3 beat -> all outputs 0 immediately; after release, a new single read at address 1 returns regs_in[1].
